// File: rtl/ps2_pkg.sv
// ps2_pkg: shared types, constants and helpers for the PS/2 receive path.
//   ps2_state_e     - receive FSM states (IDLE, DATA, PARITY, STOP)
//   DATA_BITS       - data bits per PS/2 frame
//   timeout_cycles  - converts a clock rate and a timeout in microseconds
//                     into a number of clock cycles
//   odd_parity_ok   - true when data bits plus parity bit hold an odd
//                     number of ones
package ps2_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_e;

  // 64-bit intermediate so CLK_HZ * TIMEOUT_US cannot overflow.
  function automatic int timeout_cycles(input longint clk_hz, input longint timeout_us);
    longint prod;
    prod = (clk_hz * timeout_us) / 64'sd1000000;
    return 32'(prod);
  endfunction

  function automatic logic odd_parity_ok(input logic [DATA_BITS-1:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_sync_filter.sv
// ps2_sync_filter: 2-FF synchroniser plus glitch filter for one PS/2 line.
// The filtered output only follows the synchronised input after FILTER_LEN
// consecutive samples that differ from the current filtered value.
// Ports:
//   clk       - system clock
//   rst       - synchronous active-high reset (line treated as idle-high)
//   line_in   - raw asynchronous PS/2 line
//   line_filt - synchronised and filtered line
module ps2_sync_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic line_in,
  output logic line_filt
);

  localparam int CNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic             meta_r;
  logic             sync_r;
  logic             filt_r;
  logic [CNT_W-1:0] cnt_r;

  // Two-stage synchroniser for the asynchronous line.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_r <= 1'b1;
      sync_r <= 1'b1;
    end else begin
      meta_r <= line_in;
      sync_r <= meta_r;
    end
  end

  // Run-length filter: count consecutive samples that disagree with the
  // filtered value; any agreeing sample restarts the run.
  always_ff @(posedge clk) begin
    if (rst) begin
      filt_r <= 1'b1;
      cnt_r  <= CNT_W'(0);
    end else if (sync_r == filt_r) begin
      cnt_r <= CNT_W'(0);
    end else if (cnt_r == CNT_W'(FILTER_LEN - 1)) begin
      filt_r <= sync_r;
      cnt_r  <= CNT_W'(0);
    end else begin
      cnt_r <= cnt_r + CNT_W'(1);
    end
  end

  assign line_filt = filt_r;

endmodule

// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo: PS/2 keyboard receiver with a show-ahead scancode FIFO.
// Optional feature macro: PS2_PARITY_CHECK_EN (enables odd-parity checking;
// when undefined the parity bit is captured but ignored).
// Ports:
//   clk, rst                  - system clock, synchronous active-high reset
//   ps2_clk, ps2_data         - raw asynchronous PS/2 lines (idle high)
//   rd_en                     - pop the FIFO head (ignored when empty)
//   rd_data, rd_valid         - FIFO head scancode and not-empty flag
//   frame_err                 - one-cycle pulse per rejected/aborted frame
//   overflow                  - sticky, a byte was dropped on a full FIFO
//   ps2_clk_out, ps2_data_out - filtered lines for monitoring
module ps2_rx_fifo import ps2_pkg::*; #(
  parameter int CLK_HZ     = 27000000,
  parameter int FIFO_DEPTH = 8,
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT_US = 2000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ps2_clk,
  input  logic                 ps2_data,
  input  logic                 rd_en,
  output logic [DATA_BITS-1:0] rd_data,
  output logic                 rd_valid,
  output logic                 frame_err,
  output logic                 overflow,
  output logic                 ps2_clk_out,
  output logic                 ps2_data_out
);

  localparam int TMO_CYC   = timeout_cycles(longint'(CLK_HZ), longint'(TIMEOUT_US));
  localparam int PTR_W     = $clog2(FIFO_DEPTH);
  localparam int CNT_W     = $clog2(FIFO_DEPTH + 1);
  localparam int BIT_CNT_W = $clog2(DATA_BITS);

  logic                 clk_filt_s, data_filt_s, clk_prev_r, fall_s;
  ps2_state_e           state_r, state_nxt_s;
  logic [BIT_CNT_W-1:0] bit_cnt_r;
  logic [DATA_BITS-1:0] shift_r;
  logic                 par_r, parity_ok_s;
  logic [31:0]          tmo_cnt_r;
  logic                 tmo_s, push_s, frame_err_s, frame_err_r, overflow_r;
  logic [DATA_BITS-1:0] mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_r, rd_ptr_r;
  logic [CNT_W-1:0]     count_r;
  logic                 full_s, pop_s, wr_ok_s;

  ps2_sync_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
    .clk(clk), .rst(rst), .line_in(ps2_clk), .line_filt(clk_filt_s)
  );
  ps2_sync_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filt (
    .clk(clk), .rst(rst), .line_in(ps2_data), .line_filt(data_filt_s)
  );

  // Strobe is high in the first cycle the filtered clock reads low.
  assign fall_s = clk_prev_r & ~clk_filt_s;
  assign tmo_s  = (state_r != IDLE) && !fall_s && (tmo_cnt_r == 32'(TMO_CYC - 1));

`ifdef PS2_PARITY_CHECK_EN
  assign parity_ok_s = odd_parity_ok(shift_r, par_r);
`else
  // Parity bit is still captured; OR-ing with 1 keeps it from gating the push.
  assign parity_ok_s = odd_parity_ok(shift_r, par_r) | 1'b1;
`endif

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_nxt_s;
  end

  // FSM next-state logic; a timeout always returns to IDLE.
  always_comb begin
    state_nxt_s = state_r;
    if (tmo_s) begin
      state_nxt_s = IDLE;
    end else if (fall_s) begin
      case (state_r)
        IDLE:    if (!data_filt_s) state_nxt_s = DATA; else state_nxt_s = IDLE;
        DATA:    if (bit_cnt_r == BIT_CNT_W'(DATA_BITS - 1)) state_nxt_s = PARITY;
                 else state_nxt_s = DATA;
        PARITY:  state_nxt_s = STOP;
        STOP:    state_nxt_s = IDLE;
        default: state_nxt_s = IDLE;
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // FSM outputs: FIFO push request and frame error request.
  always_comb begin
    push_s      = 1'b0;
    frame_err_s = 1'b0;
    if (tmo_s) begin
      frame_err_s = 1'b1;
    end else if (fall_s) begin
      case (state_r)
        IDLE:    if (data_filt_s) frame_err_s = 1'b1; else frame_err_s = 1'b0;
        STOP:    if (data_filt_s && parity_ok_s) push_s = 1'b1; else frame_err_s = 1'b1;
        default: begin push_s = 1'b0; frame_err_s = 1'b0; end
      endcase
    end else begin
      push_s      = 1'b0;
      frame_err_s = 1'b0;
    end
  end

  // Frame datapath: edge history, bit counter, LSB-first shifter, parity bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_prev_r <= 1'b1;
      bit_cnt_r  <= BIT_CNT_W'(0);
      shift_r    <= DATA_BITS'(0);
      par_r      <= 1'b0;
    end else begin
      clk_prev_r <= clk_filt_s;
      if (tmo_s) begin
        shift_r <= DATA_BITS'(0);
      end else if (fall_s) begin
        case (state_r)
          IDLE: begin
            bit_cnt_r <= BIT_CNT_W'(0);
            shift_r   <= DATA_BITS'(0);
          end
          DATA: begin
            shift_r   <= {data_filt_s, shift_r[DATA_BITS-1:1]};
            bit_cnt_r <= bit_cnt_r + BIT_CNT_W'(1);
          end
          PARITY:  par_r <= data_filt_s;
          default: par_r <= par_r;
        endcase
      end
    end
  end

  // Inter-edge timeout counter, only running inside a frame.
  always_ff @(posedge clk) begin
    if (rst || state_r == IDLE || fall_s || tmo_s) tmo_cnt_r <= 32'd0;
    else                                           tmo_cnt_r <= tmo_cnt_r + 32'd1;
  end

  // Registered frame error pulse.
  always_ff @(posedge clk) begin
    if (rst) frame_err_r <= 1'b0;
    else     frame_err_r <= frame_err_s;
  end

  assign full_s  = (count_r == CNT_W'(FIFO_DEPTH));
  assign pop_s   = rd_en && (count_r != CNT_W'(0));
  assign wr_ok_s = push_s && (!full_s || pop_s);

  // FIFO storage; flushing is done through the pointers, not the array.
  always_ff @(posedge clk) begin
    if (!rst && wr_ok_s) mem_r[wr_ptr_r] <= shift_r;
  end

  // FIFO pointers, occupancy and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r   <= PTR_W'(0);
      rd_ptr_r   <= PTR_W'(0);
      count_r    <= CNT_W'(0);
      overflow_r <= 1'b0;
    end else begin
      if (wr_ok_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      if (pop_s)   rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      case ({wr_ok_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
      if (push_s && full_s && !pop_s) overflow_r <= 1'b1;
    end
  end

  assign rd_valid     = (count_r != CNT_W'(0));
  assign rd_data      = rd_valid ? mem_r[rd_ptr_r] : DATA_BITS'(0);
  assign frame_err    = frame_err_r;
  assign overflow     = overflow_r;
  assign ps2_clk_out  = clk_filt_s;
  assign ps2_data_out = data_filt_s;

endmodule

// File: doc/ps2_rx_fifo.md
PS2_RX_FIFO -- requirements
Module: ps2_rx_fifo

Interface
REQ-001 Parameter CLK_HZ, 27000000, system clock frequency in Hz.
REQ-002 Parameter FIFO_DEPTH, 8, scancode FIFO entries; power of two, >=2.
REQ-003 Parameter FILTER_LEN, 8, consecutive equal samples needed to accept a PS/2 line change; >=2.
REQ-004 Parameter TIMEOUT_US, 2000, maximum gap between falling edges inside one frame, in microseconds.
REQ-005 clk  in  1  system clock; the only clock.
REQ-006 rst  in  1  reset; synchronous, active-high.
REQ-007 ps2_clk  in  1  PS/2 clock from keyboard; asynchronous; idles high.
REQ-008 ps2_data  in  1  PS/2 data from keyboard; asynchronous; idles high.
REQ-009 rd_en  in  1  pop request for the FIFO head.
REQ-010 rd_data  out  8  FIFO head scancode; valid while rd_valid=1.
REQ-011 rd_valid  out  1  FIFO not empty.
REQ-012 frame_err  out  1  one-cycle pulse for each rejected or aborted frame.
REQ-013 overflow  out  1  sticky: a byte was dropped because the FIFO was full.
REQ-014 ps2_clk_out  out  1  filtered PS/2 clock for scope monitoring.
REQ-015 ps2_data_out  out  1  filtered PS/2 data for scope monitoring.

Function
REQ-016 Each PS/2 line SHALL pass through a 2-FF synchroniser followed by a filter; the filtered value changes only after FILTER_LEN consecutive identical synchronised samples.
REQ-017 A falling edge SHALL be a one-cycle strobe, asserted in the cycle after filtered ps2_clk goes from 1 to 0; filtered ps2_data is sampled on that strobe.
REQ-018 The FSM SHALL have four states: IDLE, DATA, PARITY, STOP.
REQ-019 IDLE: on a strobe with data=0, go to DATA and clear the bit count; on a strobe with data=1, stay in IDLE and pulse frame_err.
REQ-020 DATA: shift in 8 bits LSB-first, one per strobe, then go to PARITY.
REQ-021 PARITY: capture the bit on the strobe and go to STOP.
REQ-022 STOP: on the strobe, return to IDLE; push the byte if stop=1 and the frame passes the REQ-032/033 parity rule, otherwise pulse frame_err.
REQ-023 In any state other than IDLE, if CLK_HZ*TIMEOUT_US/1e6 cycles pass without a strobe, go to IDLE, pulse frame_err, and discard the partial byte.
REQ-024 A pushed byte SHALL appear at rd_data with rd_valid=1 in the cycle after the stop-bit strobe (FIFO empty case).
REQ-025 The FIFO SHALL be show-ahead: rd_en with rd_valid=1 pops, and the next entry (or rd_valid=0) is presented in the following cycle; rd_en with rd_valid=0 is ignored.
REQ-026 Push while full without a simultaneous pop SHALL drop the new byte and set overflow; push and pop in the same cycle while full SHALL both succeed.
REQ-027 Read and write pointers SHALL wrap modulo FIFO_DEPTH; the occupancy count width SHALL be $clog2(FIFO_DEPTH+1).

Reset
REQ-028 During rst, synchroniser and filter registers SHALL load 1 (idle); ps2_clk_out=1, ps2_data_out=1.
REQ-029 During rst, the FSM SHALL go to IDLE, the FIFO SHALL be flushed, and rd_valid=0, rd_data=0, frame_err=0, overflow=0.
REQ-030 Reset asserted mid-frame SHALL abort the frame with no frame_err pulse.
REQ-031 Overflow SHALL clear only on rst.

Configuration
REQ-032 With PS2_PARITY_CHECK_EN defined, a frame SHALL be accepted only with odd parity over the 8 data bits plus the parity bit; a parity failure SHALL drop the byte and pulse frame_err.
REQ-033 Without PS2_PARITY_CHECK_EN, the parity bit SHALL be captured but ignored, and only the stop bit is checked.

Structure
REQ-034 Package ps2_pkg SHALL hold the FSM state enum, DATA_BITS=8, and a function that converts CLK_HZ and TIMEOUT_US into a cycle count.
REQ-035 Sub-module ps2_sync_filter (synchroniser plus filter, parameter FILTER_LEN) SHALL be instantiated once per PS/2 line; the FSM and FIFO stay in ps2_rx_fifo.

Verification
REQ-036 Valid frame for 0x1C (start 0, bits 0,0,1,1,1,0,0,0, parity 0, stop 1) -> rd_valid=1, rd_data=0x1C one cycle after the stop strobe; frame_err stays 0.
REQ-037 0x1C frame with parity=1 -> with the macro: frame_err pulses once and rd_valid stays 0; without the macro: 0x1C is pushed.
REQ-038 Nine valid frames 0x01..0x09 with no reads -> overflow=1; eight pops return 0x01..0x08; rd_valid=0 afterwards.
REQ-039 3-cycle low glitch on ps2_clk with FILTER_LEN=8 -> no strobe, FSM stays in IDLE, ps2_clk_out stays 1.
REQ-040 Start bit plus 4 bits, then silence -> frame_err pulses after the timeout and the FSM returns to IDLE; a following 0xF0 frame is received correctly.
REQ-041 rst asserted during DATA bit 5 -> FIFO empty, FSM in IDLE, no frame_err; a following 0x5A frame is received correctly.
